// File: rtl/mem_port_arbiter.sv
// Three-requester round-robin arbiter (instruction fetch, load/store, debug)
// in front of one single-port BRAM with one-cycle read latency.
module mem_port_arbiter #(
  parameter int unsigned MEM_WORDS = 3000,
  parameter int unsigned AW        = 12
) (
  input  logic          clock_1hz,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [3:0]    ls_be,
  input  logic [31:0]   ls_addr,
  input  logic [31:0]   ls_wdata,
  input  logic          dbg_req,
  input  logic [31:0]   dbg_addr,
  output logic          if_ack,
  output logic          ls_ack,
  output logic          dbg_ack,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    last_gnt
);

  typedef enum logic [1:0] {
    SRC_IF  = 2'd0,
    SRC_LS  = 2'd1,
    SRC_DBG = 2'd2
  } src_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  src_e          last_gnt_q, last_gnt_d;
  logic          infl_v_q,   infl_v_d;
  src_e          infl_id_q,  infl_id_d;
  logic          infl_err_q, infl_err_d;
  logic          infl_wr_q,  infl_wr_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [31:0]   wdata_q,    wdata_d;

  logic [2:0]    req_vec;
  logic [2:0]    elig;
  logic          gnt_v;
  logic          grant;
  src_e          gnt_id;
  logic [1:0]    rr_idx;
  logic [31:0]   sel_addr;
  logic          sel_wr;
  logic          sel_err;

  assign req_vec = {dbg_req, ls_req, if_req};

  // The requester granted last cycle is still waiting for its ack, so it sits out.
  always_comb begin
    elig = req_vec;
    if (infl_v_q) begin
      case (infl_id_q)
        SRC_IF:  elig[0] = 1'b0;
        SRC_LS:  elig[1] = 1'b0;
        default: elig[2] = 1'b0;
      endcase
    end
  end

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = last_gnt_q;
    rr_idx = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      rr_idx = 2'((32'(last_gnt_q) + k) % 3);
      if (!gnt_v && elig[rr_idx]) begin
        gnt_v  = 1'b1;
        gnt_id = src_e'(rr_idx);
      end
    end
  end

  // Reset blocks grants combinationally so mem_en cannot glitch while rst_n is low.
  assign grant = gnt_v && rst_n;

  always_comb begin
    case (gnt_id)
      SRC_IF:  sel_addr = if_addr;
      SRC_LS:  sel_addr = ls_addr;
      default: sel_addr = dbg_addr;
    endcase
    sel_wr  = (gnt_id == SRC_LS) && ls_we;
    sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (grant) begin
      mem_en    = !sel_err;
      mem_we    = (sel_wr && !sel_err) ? ls_be : 4'b0000;
      mem_addr  = sel_addr[AW+1:2];
      mem_wdata = ls_wdata;
    end
  end

  always_comb begin
    if_ack  = 1'b0;
    ls_ack  = 1'b0;
    dbg_ack = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    if (rst_n && infl_v_q) begin
      case (infl_id_q)
        SRC_IF:  if_ack  = 1'b1;
        SRC_LS:  ls_ack  = 1'b1;
        default: dbg_ack = 1'b1;
      endcase
      err = infl_err_q;
      if (!infl_err_q && !infl_wr_q) rdata = mem_rdata;
    end
  end

  always_comb begin
    infl_v_d   = grant;
    infl_id_d  = grant ? gnt_id : infl_id_q;
    infl_err_d = grant && sel_err;
    infl_wr_d  = grant && sel_wr;
    last_gnt_d = grant ? gnt_id : last_gnt_q;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
  end

  always_ff @(posedge clock_1hz or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= SRC_DBG;
      infl_v_q   <= 1'b0;
      infl_id_q  <= SRC_IF;
      infl_err_q <= 1'b0;
      infl_wr_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      infl_v_q   <= infl_v_d;
      infl_id_q  <= infl_id_d;
      infl_err_q <= infl_err_d;
      infl_wr_q  <= infl_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign last_gnt = last_gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a request-level arbitration/memory reference model.
module tb_mem_port_arbiter;
  localparam int unsigned MEM_WORDS = 3000;
  localparam int unsigned AW        = 12;
  localparam logic [31:0] LIMIT     = 32'(MEM_WORDS * 4);

  logic          clock_1hz = 1'b0;
  logic          rst_n;
  logic          if_req, ls_req, ls_we, dbg_req;
  logic [31:0]   if_addr, ls_addr, ls_wdata, dbg_addr;
  logic [3:0]    ls_be;
  logic          if_ack, ls_ack, dbg_ack, err, mem_en;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    last_gnt;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] bram    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  always #5 clock_1hz = ~clock_1hz;

  mem_port_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clock_1hz(clock_1hz), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .if_ack(if_ack), .ls_ack(ls_ack), .dbg_ack(dbg_ack),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .last_gnt(last_gnt)
  );

  // Called at the negedge: samples the settled BRAM port, crosses the posedge,
  // and performs the BRAM access (read-first, byte-enabled write).
  task automatic step();
    logic          e;
    logic [3:0]    w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    e = mem_en; w = mem_we; a = mem_addr; d = mem_wdata;
    @(posedge clock_1hz); #1;
    if (e && 32'(a) < MEM_WORDS) begin
      mem_rdata = bram[a];
      for (int b = 0; b < 4; b++) if (w[b]) bram[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic clear_reqs();
    if_req = 1'b0; ls_req = 1'b0; dbg_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; if_addr = 32'h8;
    ls_req = 1'b1; ls_addr = 32'h10; ls_we = 1'b1; ls_be = 4'hF; ls_wdata = 32'h1234_5678;
    dbg_req = 1'b1; dbg_addr = 32'h20;
    #1;
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b, expected 0", mem_en); end
    vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("FAIL rst_mem_we: got %h, expected 0", mem_we); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr: got %h, expected 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h, expected 0", mem_wdata); end
    vectors++; if (last_gnt !== 2'd2) begin miscompares++; $display("FAIL rst_last_gnt: got %0d, expected 2", last_gnt); end
    vectors++; if ({dbg_ack, ls_ack, if_ack} !== 3'b000) begin miscompares++; $display("FAIL rst_acks: got %b, expected 000", {dbg_ack, ls_ack, if_ack}); end
    vectors++; if ({err, rdata} !== 33'h0) begin miscompares++; $display("FAIL rst_err_rdata: got %b/%h, expected 0/0", err, rdata); end
    @(negedge clock_1hz); step(); @(negedge clock_1hz); step();
    @(negedge clock_1hz);
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_hold_mem_en: got %b, expected 0", mem_en); end
    vectors++; if ({dbg_ack, ls_ack, if_ack} !== 3'b000) begin miscompares++; $display("FAIL rst_hold_acks: got %b, expected 000", {dbg_ack, ls_ack, if_ack}); end
    step();
    clear_reqs(); rst_n = 1'b1;
    @(negedge clock_1hz);
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rel_idle_mem_en: got %b, expected 0", mem_en); end
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clock_1hz);
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_en: got %b, expected 1", mem_en); end
    vectors++; if (mem_addr !== AW'(2)) begin miscompares++; $display("FAIL fetch_mem_addr: got %h, expected 2", mem_addr); end
    vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("FAIL fetch_mem_we: got %h, expected 0", mem_we); end
    step();
    @(negedge clock_1hz);
    vectors++; if (if_ack !== 1'b1) begin miscompares++; $display("FAIL fetch_ack: got %b, expected 1", if_ack); end
    vectors++; if (rdata !== 32'h9300_0201) begin miscompares++; $display("FAIL fetch_rdata: got %h, expected 93000201", rdata); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL fetch_err: got %b, expected 0", err); end
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL fetch_no_regrant: got %b, expected 0", mem_en); end
    vectors++; if (last_gnt !== 2'd0) begin miscompares++; $display("FAIL fetch_last_gnt: got %0d, expected 0", last_gnt); end
    step();
    if_req = 1'b0;
    @(negedge clock_1hz);
    vectors++; if (if_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_single_ack: got %b, expected 0", if_ack); end
    vectors++; if (mem_addr !== AW'(2)) begin miscompares++; $display("FAIL idle_addr_hold: got %h, expected 2", mem_addr); end
    step();
  endtask

  task automatic test_write();
    logic [31:0] merged;
    merged = {ref_mem[4][31:16], 16'hCCDD};
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h10; ls_wdata = 32'hAABB_CCDD;
    @(negedge clock_1hz);
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL wr_mem_en: got %b, expected 1", mem_en); end
    vectors++; if (mem_we !== 4'b0011) begin miscompares++; $display("FAIL wr_mem_we: got %b, expected 0011", mem_we); end
    vectors++; if (mem_addr !== AW'(4)) begin miscompares++; $display("FAIL wr_mem_addr: got %h, expected 4", mem_addr); end
    vectors++; if (mem_wdata !== 32'hAABB_CCDD) begin miscompares++; $display("FAIL wr_mem_wdata: got %h, expected aabbccdd", mem_wdata); end
    step();
    ref_mem[4] = merged;
    @(negedge clock_1hz);
    vectors++; if ({ls_ack, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL wr_ack: got ack=%b err=%b rdata=%h, expected ack=1 err=0 rdata=0", ls_ack, err, rdata); end
    step();
    ls_req = 1'b0; ls_we = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h10;
    @(negedge clock_1hz);
    vectors++; if ({mem_en, mem_we} !== 5'b1_0000) begin miscompares++; $display("FAIL dbg_read_port: got en=%b we=%b, expected en=1 we=0000", mem_en, mem_we); end
    step();
    @(negedge clock_1hz);
    vectors++; if ({dbg_ack, rdata} !== {1'b1, merged}) begin miscompares++; $display("FAIL dbg_readback: got ack=%b rdata=%h, expected ack=1 rdata=%h", dbg_ack, rdata, merged); end
    step();
    dbg_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0000; ls_addr = 32'h14;
    @(negedge clock_1hz);
    vectors++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'h0, AW'(5)}) begin miscompares++; $display("FAIL noop_wr_port: got en=%b we=%b addr=%h, expected en=1 we=0000 addr=5", mem_en, mem_we, mem_addr); end
    step();
    @(negedge clock_1hz);
    vectors++; if ({ls_ack, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL noop_wr_ack: got ack=%b err=%b rdata=%h, expected ack=1 err=0 rdata=0", ls_ack, err, rdata); end
    step();
    clear_reqs();
  endtask

  task automatic test_error();
    logic [31:0] bad [3];
    bad[0] = 32'h2EE0; bad[1] = 32'h6; bad[2] = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      dbg_req = 1'b1; dbg_addr = bad[i];
      @(negedge clock_1hz);
      vectors++; if ({mem_en, mem_we} !== 5'b0) begin miscompares++; $display("FAIL err_port[%0d]: got en=%b we=%b, expected 0/0000", i, mem_en, mem_we); end
      step();
      @(negedge clock_1hz);
      vectors++; if ({dbg_ack, err, rdata} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL err_ack[%0d]: got ack=%b err=%b rdata=%h, expected 1/1/0", i, dbg_ack, err, rdata); end
      step();
      dbg_req = 1'b0;
    end
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h2EE0; ls_wdata = 32'hDEAD_0001;
    @(negedge clock_1hz);
    vectors++; if ({mem_en, mem_we} !== 5'b0) begin miscompares++; $display("FAIL err_wr_port: got en=%b we=%b, expected 0/0000", mem_en, mem_we); end
    step();
    @(negedge clock_1hz);
    vectors++; if ({ls_ack, err, rdata} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL err_wr_ack: got ack=%b err=%b rdata=%h, expected 1/1/0", ls_ack, err, rdata); end
    step();
    clear_reqs(); dbg_req = 1'b1; dbg_addr = 32'h2EDC;
    @(negedge clock_1hz);
    vectors++; if ({mem_en, mem_addr} !== {1'b1, AW'(MEM_WORDS - 1)}) begin miscompares++; $display("FAIL top_word_port: got en=%b addr=%h, expected en=1 addr=%h", mem_en, mem_addr, AW'(MEM_WORDS - 1)); end
    step();
    @(negedge clock_1hz);
    vectors++; if ({dbg_ack, err, rdata} !== {2'b10, ref_mem[MEM_WORDS-1]}) begin miscompares++; $display("FAIL top_word_ack: got ack=%b err=%b rdata=%h, expected 1/0/%h", dbg_ack, err, rdata, ref_mem[MEM_WORDS-1]); end
    step();
    dbg_req = 1'b0;
  endtask

  task automatic test_round_robin();
    int id;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44; dbg_req = 1'b1; dbg_addr = 32'h48;
    @(negedge clock_1hz);
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rr_reset_en: got %b, expected 0", mem_en); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock_1hz);
      id = c % 3;
      vectors++; if ({mem_en, mem_addr} !== {1'b1, AW'(16 + id)}) begin miscompares++; $display("FAIL rr_grant[%0d]: got en=%b addr=%h, expected en=1 addr=%h", c, mem_en, mem_addr, AW'(16 + id)); end
      if (c >= 1) begin
        id = (c - 1) % 3;
        vectors++; if ({dbg_ack, ls_ack, if_ack} !== 3'(1 << id)) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b, expected %b", c, {dbg_ack, ls_ack, if_ack}, 3'(1 << id)); end
        vectors++; if (rdata !== ref_mem[16 + id]) begin miscompares++; $display("FAIL rr_rdata[%0d]: got %h, expected %h", c, rdata, ref_mem[16 + id]); end
      end
      step();
    end
    clear_reqs();
    @(negedge clock_1hz);
    vectors++; if ({dbg_ack, ls_ack, if_ack} !== 3'b100) begin miscompares++; $display("FAIL rr_last_ack: got %b, expected 100", {dbg_ack, ls_ack, if_ack}); end
    step();
  endtask

  task automatic test_reset_inflight();
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clock_1hz);
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL rif_grant: got %b, expected 1", mem_en); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rif_async_en: got %b, expected 0", mem_en); end
    step();
    if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44; dbg_req = 1'b1; dbg_addr = 32'h48;
    rst_n = 1'b1;
    @(negedge clock_1hz);
    vectors++; if ({dbg_ack, ls_ack, if_ack} !== 3'b000) begin miscompares++; $display("FAIL rif_dropped_ack: got %b, expected 000", {dbg_ack, ls_ack, if_ack}); end
    vectors++; if ({mem_en, mem_addr} !== {1'b1, AW'(16)}) begin miscompares++; $display("FAIL rif_first_if: got en=%b addr=%h, expected en=1 addr=10", mem_en, mem_addr); end
    step();
    @(negedge clock_1hz);
    vectors++; if ({if_ack, rdata} !== {1'b1, ref_mem[16]}) begin miscompares++; $display("FAIL rif_if_ack: got ack=%b rdata=%h, expected 1/%h", if_ack, rdata, ref_mem[16]); end
    step();
    clear_reqs();
    @(negedge clock_1hz);
    vectors++; if ({ls_ack, rdata} !== {1'b1, ref_mem[17]}) begin miscompares++; $display("FAIL drop_after_grant_ack: got ack=%b rdata=%h, expected 1/%h", ls_ack, rdata, ref_mem[17]); end
    step();
    @(negedge clock_1hz); step();
  endtask

  task automatic test_ls_only();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_1hz);
      if (c % 2 == 0) begin
        vectors++; if ({mem_en, mem_addr, ls_ack} !== {1'b1, AW'(8), 1'b0}) begin miscompares++; $display("FAIL ls_only_grant[%0d]: got en=%b addr=%h ack=%b, expected 1/8/0", c, mem_en, mem_addr, ls_ack); end
      end else begin
        vectors++; if ({mem_en, ls_ack, rdata} !== {2'b01, ref_mem[8]}) begin miscompares++; $display("FAIL ls_only_gap[%0d]: got en=%b ack=%b rdata=%h, expected 0/1/%h", c, mem_en, ls_ack, rdata, ref_mem[8]); end
      end
      if (c >= 1) begin
        vectors++; if (last_gnt !== 2'd1) begin miscompares++; $display("FAIL ls_only_last_gnt[%0d]: got %0d, expected 1", c, last_gnt); end
      end
      step();
    end
    clear_reqs();
    @(negedge clock_1hz); step();
  endtask

  function automatic logic [31:0] gen_addr();
    int unsigned r;
    r = $urandom % 100;
    if (r < 70)      return ($urandom % 64) * 4;
    else if (r < 80) return (MEM_WORDS - 1 - ($urandom % 4)) * 4;
    else if (r < 88) return ($urandom % 64) * 4 + 1 + ($urandom % 3);
    else if (r < 95) return LIMIT + ($urandom % 16) * 4;
    else             return $urandom;
  endfunction

  task automatic test_random();
    bit            act [3];
    bit            gnt [3];
    logic [31:0]   raddr [3];
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    int            m_last, m_id, g, cand;
    bit            m_v, m_err, gerr, gwr;
    logic [31:0]   m_rdata, ga;
    logic [AW-1:0] m_hold_addr, exp_addr;
    logic [31:0]   m_hold_wdata, exp_wdata;
    logic          exp_en;
    logic [3:0]    exp_we;
    logic [2:0]    exp_ack;

    clear_reqs(); rst_n = 1'b0;
    @(negedge clock_1hz); step();
    rst_n = 1'b1;
    m_last = 2; m_v = 1'b0; m_id = 0; m_err = 1'b0; m_rdata = '0;
    m_hold_addr = '0; m_hold_wdata = '0;
    r_we = 1'b0; r_be = '0; r_wdata = '0;
    for (int r = 0; r < 3; r++) begin act[r] = 1'b0; gnt[r] = 1'b0; raddr[r] = '0; end

    for (int c = 0; c < 1500; c++) begin
      if_req  = act[0]; if_addr  = act[0] ? raddr[0] : $urandom;
      ls_req  = act[1]; ls_addr  = act[1] ? raddr[1] : $urandom;
      ls_we   = act[1] ? r_we : 1'($urandom);
      ls_be   = act[1] ? r_be : 4'($urandom);
      ls_wdata = act[1] ? r_wdata : $urandom;
      dbg_req = act[2]; dbg_addr = act[2] ? raddr[2] : $urandom;

      g = -1;
      for (int k = 1; k <= 3; k++) begin
        cand = (m_last + k) % 3;
        if (g < 0 && act[cand] && !(m_v && m_id == cand)) g = cand;
      end
      gerr = 1'b0; gwr = 1'b0; ga = '0;
      if (g >= 0) begin
        ga = (g == 0) ? if_addr : (g == 1) ? ls_addr : dbg_addr;
        gerr = (ga % 4 != 0) || (ga >= LIMIT);
        gwr = (g == 1) && ls_we;
        exp_en = !gerr;
        exp_we = (gwr && !gerr) ? ls_be : 4'h0;
        exp_addr = AW'(ga / 4);
        exp_wdata = ls_wdata;
      end else begin
        exp_en = 1'b0; exp_we = 4'h0; exp_addr = m_hold_addr; exp_wdata = m_hold_wdata;
      end
      exp_ack = m_v ? 3'(1 << m_id) : 3'b000;

      @(negedge clock_1hz);
      vectors++; if (mem_en !== exp_en) begin miscompares++; $display("FAIL rnd_mem_en[%0d]: got %b, expected %b", c, mem_en, exp_en); end
      vectors++; if (mem_we !== exp_we) begin miscompares++; $display("FAIL rnd_mem_we[%0d]: got %b, expected %b", c, mem_we, exp_we); end
      vectors++; if (mem_addr !== exp_addr) begin miscompares++; $display("FAIL rnd_mem_addr[%0d]: got %h, expected %h", c, mem_addr, exp_addr); end
      vectors++; if (mem_wdata !== exp_wdata) begin miscompares++; $display("FAIL rnd_mem_wdata[%0d]: got %h, expected %h", c, mem_wdata, exp_wdata); end
      vectors++; if (last_gnt !== 2'(m_last)) begin miscompares++; $display("FAIL rnd_last_gnt[%0d]: got %0d, expected %0d", c, last_gnt, m_last); end
      vectors++; if ({dbg_ack, ls_ack, if_ack} !== exp_ack) begin miscompares++; $display("FAIL rnd_acks[%0d]: got %b, expected %b", c, {dbg_ack, ls_ack, if_ack}, exp_ack); end
      if (m_v) begin
        vectors++; if ({err, rdata} !== {m_err, m_rdata}) begin miscompares++; $display("FAIL rnd_resp[%0d]: got err=%b rdata=%h, expected err=%b rdata=%h", c, err, rdata, m_err, m_rdata); end
      end
      step();

      if (m_v) begin act[m_id] = 1'b0; gnt[m_id] = 1'b0; end
      if (g >= 0) begin
        m_v = 1'b1; m_id = g; m_err = gerr;
        m_rdata = (gerr || gwr) ? 32'h0 : ref_mem[ga / 4];
        if (gwr && !gerr)
          for (int b = 0; b < 4; b++) if (ls_be[b]) ref_mem[ga / 4][8*b +: 8] = ls_wdata[8*b +: 8];
        m_last = g; m_hold_addr = exp_addr; m_hold_wdata = exp_wdata;
        gnt[g] = 1'b1;
      end else begin
        m_v = 1'b0;
      end

      for (int r = 0; r < 3; r++) begin
        if (!act[r]) begin
          if ($urandom % 100 < 55) begin
            act[r] = 1'b1; gnt[r] = 1'b0; raddr[r] = gen_addr();
            if (r == 1) begin r_we = 1'($urandom); r_be = 4'($urandom); r_wdata = $urandom; end
          end
        end else if (!gnt[r] && ($urandom % 100 < 8)) begin
          act[r] = 1'b0;
        end
      end
    end
    clear_reqs();
    @(negedge clock_1hz); step();
    @(negedge clock_1hz); step();
  endtask

  initial begin
    rst_n = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; dbg_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0;
    if_addr = '0; ls_addr = '0; dbg_addr = '0; ls_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) bram[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    bram[2] = 32'h9300_0201;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = bram[i];
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    test_fetch();
    test_write();
    test_error();
    test_round_robin();
    test_reset_inflight();
    test_ls_only();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
